// File: rtl/psd_lpf_ctrl.sv
// psd_lpf_ctrl
//   Configuration and capture controller for the PSD low-pass filter bank.
//   A new coefficient/slope pair is accepted through a valid/ready handshake
//   and driven to the filter. The block then waits for the filter to settle
//   before reporting lock. Once locked, single-cycle measurement requests
//   snapshot the four filter outputs.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_cfg_valid/o_cfg_ready configuration handshake
//   i_cfg_coef, i_cfg_mod   requested coefficient (shift) and slope mode
//   i_abort                 abandon settle/lock, return to IDLE
//   i_meas_req              one-cycle capture request
//   i_iir_valid             filter output valid
//   i_A_X..i_B_Y            signed 36-bit filter outputs
//   o_coefficient, o_mod    configuration currently driven to the filter
//   o_res_A_X..o_res_B_Y    captured results
//   o_res_valid             one-cycle pulse when new results are present
//   o_locked                filter settled under the current configuration
//   o_meas_err              one-cycle pulse when a request is rejected
//   o_meas_cnt              captures since the last accepted configuration
//   o_state                 FSM state (00 IDLE, 01 SETTLE, 10 LOCKED)

module psd_lpf_ctrl #(
  parameter int SETTLE_SHIFT = 3,
  parameter int PIPE_LAT     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_valid,
  input  logic [3:0]  i_cfg_coef,
  input  logic [1:0]  i_cfg_mod,
  output logic        o_cfg_ready,
  input  logic        i_abort,
  input  logic        i_meas_req,
  input  logic        i_iir_valid,
  input  logic [35:0] i_A_X,
  input  logic [35:0] i_A_Y,
  input  logic [35:0] i_B_X,
  input  logic [35:0] i_B_Y,
  output logic [3:0]  o_coefficient,
  output logic [1:0]  o_mod,
  output logic [35:0] o_res_A_X,
  output logic [35:0] o_res_A_Y,
  output logic [35:0] o_res_B_X,
  output logic [35:0] o_res_B_Y,
  output logic        o_res_valid,
  output logic        o_locked,
  output logic        o_meas_err,
  output logic [15:0] o_meas_cnt,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  coef_q, coef_d;
  logic [1:0]  mod_q, mod_d;
  logic [35:0] res_ax_q, res_ax_d;
  logic [35:0] res_ay_q, res_ay_d;
  logic [35:0] res_bx_q, res_bx_d;
  logic [35:0] res_by_q, res_by_d;
  logic        res_valid_q, res_valid_d;
  logic        locked_q, locked_d;
  logic        meas_err_q, meas_err_d;
  logic [15:0] meas_cnt_q, meas_cnt_d;

  logic        cfg_ready;
  logic        cfg_accept;
  logic [23:0] settle_len;
  logic [23:0] cnt_load;

  // Handshake and settle-length computation. The counter is loaded with
  // N-1 so that, with the filter valid throughout, lock is registered on
  // the N-th edge after acceptance. The worst case (2^20 + PIPE_LAT) fits
  // comfortably in 24 bits.
  always_comb begin
    cfg_ready  = ((state_q == IDLE) || (state_q == LOCKED)) && !i_abort;
    cfg_accept = cfg_ready && i_cfg_valid;
    settle_len = 24'(((32'(i_cfg_mod) + 32'd1) << (32'(i_cfg_coef) + 32'(SETTLE_SHIFT)))
                     + 32'(PIPE_LAT));
    cnt_load   = settle_len - 24'd1;
  end

  // Next-state and output logic. Priority: abort, then configuration
  // acceptance, then per-state behaviour. The unused encoding falls into
  // the default branch and returns to IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coef_d      = coef_q;
    mod_d       = mod_q;
    res_ax_d    = res_ax_q;
    res_ay_d    = res_ay_q;
    res_bx_d    = res_bx_q;
    res_by_d    = res_by_q;
    res_valid_d = 1'b0;
    locked_d    = locked_q;
    meas_err_d  = 1'b0;
    meas_cnt_d  = meas_cnt_q;

    if (i_abort) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      cnt_d    = 24'd0;
    end else if (cfg_accept) begin
      // Configuration wins over a simultaneous measurement request,
      // which is then reported as rejected.
      state_d    = SETTLE;
      coef_d     = i_cfg_coef;
      mod_d      = i_cfg_mod;
      cnt_d      = cnt_load;
      meas_cnt_d = 16'd0;
      locked_d   = 1'b0;
      meas_err_d = i_meas_req;
    end else begin
      unique case (state_q)
        IDLE: begin
          meas_err_d = i_meas_req;
        end
        SETTLE: begin
          meas_err_d = i_meas_req;
          // Once the count is exhausted the counter parks at zero until
          // the filter reports valid output.
          if (cnt_q != 24'd0) begin
            cnt_d = cnt_q - 24'd1;
          end else if (i_iir_valid) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
        LOCKED: begin
          if (i_meas_req) begin
            res_ax_d    = i_A_X;
            res_ay_d    = i_A_Y;
            res_bx_d    = i_B_X;
            res_by_d    = i_B_Y;
            res_valid_d = 1'b1;
            if (meas_cnt_q != 16'hFFFF) begin
              meas_cnt_d = meas_cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 24'd0;
      coef_q      <= 4'd0;
      mod_q       <= 2'd0;
      res_ax_q    <= 36'd0;
      res_ay_q    <= 36'd0;
      res_bx_q    <= 36'd0;
      res_by_q    <= 36'd0;
      res_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      meas_err_q  <= 1'b0;
      meas_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coef_q      <= coef_d;
      mod_q       <= mod_d;
      res_ax_q    <= res_ax_d;
      res_ay_q    <= res_ay_d;
      res_bx_q    <= res_bx_d;
      res_by_q    <= res_by_d;
      res_valid_q <= res_valid_d;
      locked_q    <= locked_d;
      meas_err_q  <= meas_err_d;
      meas_cnt_q  <= meas_cnt_d;
    end
  end

  assign o_cfg_ready   = cfg_ready;
  assign o_coefficient = coef_q;
  assign o_mod         = mod_q;
  assign o_res_A_X     = res_ax_q;
  assign o_res_A_Y     = res_ay_q;
  assign o_res_B_X     = res_bx_q;
  assign o_res_B_Y     = res_by_q;
  assign o_res_valid   = res_valid_q;
  assign o_locked      = locked_q;
  assign o_meas_err    = meas_err_q;
  assign o_meas_cnt    = meas_cnt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_psd_lpf_ctrl.sv
// tb_psd_lpf_ctrl
//   Self-checking bench for psd_lpf_ctrl. Expected captures are queued when
//   a measurement request is driven in LOCKED and compared by a monitor
//   whenever the controller pulses o_res_valid.

module tb_psd_lpf_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cfg_valid;
  logic [3:0]  i_cfg_coef;
  logic [1:0]  i_cfg_mod;
  logic        o_cfg_ready;
  logic        i_abort;
  logic        i_meas_req;
  logic        i_iir_valid;
  logic [35:0] i_A_X, i_A_Y, i_B_X, i_B_Y;
  logic [3:0]  o_coefficient;
  logic [1:0]  o_mod;
  logic [35:0] o_res_A_X, o_res_A_Y, o_res_B_X, o_res_B_Y;
  logic        o_res_valid;
  logic        o_locked;
  logic        o_meas_err;
  logic [15:0] o_meas_cnt;
  logic [1:0]  o_state;

  typedef struct packed {
    logic [35:0] ax;
    logic [35:0] ay;
    logic [35:0] bx;
    logic [35:0] by;
  } res_t;

  res_t expQ[$];
  res_t lastRes;
  res_t monExp;
  int   errCount   = 0;
  int   checkCount = 0;
  int   lockCycles;

  always #5 i_clk = ~i_clk;

  psd_lpf_ctrl #(.SETTLE_SHIFT(3), .PIPE_LAT(8)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cfg_valid   (i_cfg_valid),
    .i_cfg_coef    (i_cfg_coef),
    .i_cfg_mod     (i_cfg_mod),
    .o_cfg_ready   (o_cfg_ready),
    .i_abort       (i_abort),
    .i_meas_req    (i_meas_req),
    .i_iir_valid   (i_iir_valid),
    .i_A_X         (i_A_X),
    .i_A_Y         (i_A_Y),
    .i_B_X         (i_B_X),
    .i_B_Y         (i_B_Y),
    .o_coefficient (o_coefficient),
    .o_mod         (o_mod),
    .o_res_A_X     (o_res_A_X),
    .o_res_A_Y     (o_res_A_Y),
    .o_res_B_X     (o_res_B_X),
    .o_res_B_Y     (o_res_B_Y),
    .o_res_valid   (o_res_valid),
    .o_locked      (o_locked),
    .o_meas_err    (o_meas_err),
    .o_meas_cnt    (o_meas_cnt),
    .o_state       (o_state)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a configuration for one edge.
  task automatic applyConfig(input logic [3:0] coef, input logic [1:0] md);
    i_cfg_valid = 1'b1;
    i_cfg_coef  = coef;
    i_cfg_mod   = md;
    step();
    i_cfg_valid = 1'b0;
  endtask

  // Drive a measurement request with data; queue the expected capture when
  // the controller should accept it. Caller advances the clock.
  task automatic applyStimulus(input logic [35:0] ax, input logic [35:0] ay,
                               input logic [35:0] bx, input logic [35:0] by,
                               input bit expectCapture);
    res_t r;
    i_meas_req = 1'b1;
    i_A_X = ax;
    i_A_Y = ay;
    i_B_X = bx;
    i_B_Y = by;
    r = '{ax: ax, ay: ay, bx: bx, by: by};
    if (expectCapture) begin
      expQ.push_back(r);
      lastRes = r;
    end
  endtask

  // Count edges after acceptance until lock, bounded by a cycle budget.
  task automatic waitLock(input int limit, output int cycles);
    cycles = 0;
    while (o_locked !== 1'b1 && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest request.
  always begin
    @(posedge i_clk);
    #2;
    if (o_res_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("res_unexpected", 64'd1, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("res_A_X", 64'(o_res_A_X), 64'(monExp.ax));
        checkOutput("res_A_Y", 64'(o_res_A_Y), 64'(monExp.ay));
        checkOutput("res_B_X", 64'(o_res_B_X), 64'(monExp.bx));
        checkOutput("res_B_Y", 64'(o_res_B_Y), 64'(monExp.by));
      end
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_coef  = 4'd0;
    i_cfg_mod   = 2'd0;
    i_abort     = 1'b0;
    i_meas_req  = 1'b0;
    i_iir_valid = 1'b1;
    i_A_X = '0; i_A_Y = '0; i_B_X = '0; i_B_Y = '0;
    lastRes = '0;

    // Reset state
    step();
    step();
    checkOutput("rst_state", 64'(o_state), 64'd0);
    checkOutput("rst_coef", 64'(o_coefficient), 64'd0);
    checkOutput("rst_mod", 64'(o_mod), 64'd0);
    checkOutput("rst_locked", 64'(o_locked), 64'd0);
    checkOutput("rst_meas_cnt", 64'(o_meas_cnt), 64'd0);
    checkOutput("rst_res_A_X", 64'(o_res_A_X), 64'd0);
    checkOutput("rst_res_valid", 64'(o_res_valid), 64'd0);
    checkOutput("rst_meas_err", 64'(o_meas_err), 64'd0);
    checkOutput("rst_cfg_ready", 64'(o_cfg_ready), 64'd1);
    i_rst_n = 1'b1;
    step();

    // coef=0, mod=0: N = (1<<3)+8 = 16
    applyConfig(4'd0, 2'd0);
    checkOutput("c0_coef", 64'(o_coefficient), 64'd0);
    checkOutput("c0_mod", 64'(o_mod), 64'd0);
    checkOutput("c0_state", 64'(o_state), 64'd1);
    checkOutput("c0_cfg_ready", 64'(o_cfg_ready), 64'd0);
    waitLock(200, lockCycles);
    checkOutput("c0_lock_cycles", 64'(lockCycles), 64'd16);
    checkOutput("c0_state_locked", 64'(o_state), 64'd2);

    // coef=2, mod=3: N = (4<<5)+8 = 136
    applyConfig(4'd2, 2'd3);
    checkOutput("c1_coef", 64'(o_coefficient), 64'd2);
    checkOutput("c1_mod", 64'(o_mod), 64'd3);
    waitLock(400, lockCycles);
    checkOutput("c1_lock_cycles", 64'(lockCycles), 64'd136);
    applyStimulus(36'h8_0000_0001, 36'h1_2345_6789, 36'hF_FFFF_FFFE, 36'h0_0000_0042, 1'b1);
    step();
    i_meas_req = 1'b0;
    checkOutput("cap1_valid", 64'(o_res_valid), 64'd1);
    checkOutput("cap1_A_X", 64'(o_res_A_X), 64'h8_0000_0001);
    checkOutput("cap1_cnt", 64'(o_meas_cnt), 64'd1);
    step();
    checkOutput("cap1_valid_drop", 64'(o_res_valid), 64'd0);

    // Back-to-back captures
    for (int k = 0; k < 3; k++) begin
      applyStimulus(36'(64'h1000 + k), 36'($urandom), 36'($urandom), 36'($urandom), 1'b1);
      step();
    end
    i_meas_req = 1'b0;
    checkOutput("b2b_cnt", 64'(o_meas_cnt), 64'd4);
    checkOutput("b2b_valid", 64'(o_res_valid), 64'd1);

    // Filter not valid at end of count: lock waits for i_iir_valid
    i_iir_valid = 1'b0;
    applyConfig(4'd0, 2'd0);
    checkOutput("nv_meas_cnt_clr", 64'(o_meas_cnt), 64'd0);
    for (int c = 1; c <= 29; c++) begin
      step();
      if (c == 16 || c == 29) begin
        checkOutput("nv_not_locked", 64'(o_locked), 64'd0);
        checkOutput("nv_state_settle", 64'(o_state), 64'd1);
      end
    end
    i_iir_valid = 1'b1;
    step();
    checkOutput("nv_locked_at_30", 64'(o_locked), 64'd1);

    // Measurement during SETTLE, then abort
    applyConfig(4'd1, 2'd1);
    step();
    applyStimulus(36'h5_5555_5555, 36'h1, 36'h2, 36'h3, 1'b0);
    step();
    i_meas_req = 1'b0;
    checkOutput("settle_meas_err", 64'(o_meas_err), 64'd1);
    checkOutput("settle_res_keep", 64'(o_res_A_X), 64'(lastRes.ax));
    checkOutput("settle_res_keep_BY", 64'(o_res_B_Y), 64'(lastRes.by));
    step();
    checkOutput("settle_err_drop", 64'(o_meas_err), 64'd0);
    step();
    i_abort = 1'b1;
    #1;
    checkOutput("abort_ready_low", 64'(o_cfg_ready), 64'd0);
    step();
    i_abort = 1'b0;
    #1;
    checkOutput("abort_state", 64'(o_state), 64'd0);
    checkOutput("abort_locked", 64'(o_locked), 64'd0);
    checkOutput("abort_coef_kept", 64'(o_coefficient), 64'd1);
    checkOutput("abort_mod_kept", 64'(o_mod), 64'd1);
    checkOutput("abort_ready", 64'(o_cfg_ready), 64'd1);

    // Abort beats a simultaneous configuration and measurement request
    i_abort     = 1'b1;
    i_meas_req  = 1'b1;
    i_cfg_valid = 1'b1;
    i_cfg_coef  = 4'd9;
    i_cfg_mod   = 2'd2;
    step();
    i_abort     = 1'b0;
    i_meas_req  = 1'b0;
    i_cfg_valid = 1'b0;
    checkOutput("prio_no_err", 64'(o_meas_err), 64'd0);
    checkOutput("prio_state", 64'(o_state), 64'd0);
    checkOutput("prio_coef", 64'(o_coefficient), 64'd1);

    // Measurement in IDLE is rejected
    i_meas_req = 1'b1;
    step();
    i_meas_req = 1'b0;
    checkOutput("idle_meas_err", 64'(o_meas_err), 64'd1);
    checkOutput("idle_res_keep", 64'(o_res_A_X), 64'(lastRes.ax));

    // Configuration wins over capture in LOCKED, then reset mid-SETTLE
    applyConfig(4'd0, 2'd0);
    waitLock(200, lockCycles);
    checkOutput("c2_lock_cycles", 64'(lockCycles), 64'd16);
    applyStimulus(36'h0_ABCD_0123, 36'h7, 36'h8, 36'h9, 1'b1);
    step();
    i_meas_req = 1'b0;
    checkOutput("c2_cnt", 64'(o_meas_cnt), 64'd1);
    i_cfg_valid = 1'b1;
    i_cfg_coef  = 4'd3;
    i_cfg_mod   = 2'd2;
    applyStimulus(36'h3_3333_3333, 36'h4, 36'h5, 36'h6, 1'b0);
    step();
    i_cfg_valid = 1'b0;
    i_meas_req  = 1'b0;
    checkOutput("win_state", 64'(o_state), 64'd1);
    checkOutput("win_meas_cnt", 64'(o_meas_cnt), 64'd0);
    checkOutput("win_meas_err", 64'(o_meas_err), 64'd1);
    checkOutput("win_res_valid", 64'(o_res_valid), 64'd0);
    checkOutput("win_locked", 64'(o_locked), 64'd0);
    checkOutput("win_coef", 64'(o_coefficient), 64'd3);
    checkOutput("win_mod", 64'(o_mod), 64'd2);
    step();
    step();
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 64'(o_state), 64'd0);
    checkOutput("arst_coef", 64'(o_coefficient), 64'd0);
    checkOutput("arst_mod", 64'(o_mod), 64'd0);
    checkOutput("arst_res_A_X", 64'(o_res_A_X), 64'd0);
    checkOutput("arst_res_A_Y", 64'(o_res_A_Y), 64'd0);
    checkOutput("arst_res_B_X", 64'(o_res_B_X), 64'd0);
    checkOutput("arst_res_B_Y", 64'(o_res_B_Y), 64'd0);
    checkOutput("arst_locked", 64'(o_locked), 64'd0);
    checkOutput("arst_meas_cnt", 64'(o_meas_cnt), 64'd0);
    checkOutput("arst_meas_err", 64'(o_meas_err), 64'd0);
    checkOutput("arst_res_valid", 64'(o_res_valid), 64'd0);
    step();
    i_rst_n = 1'b1;
    step();
    checkOutput("rel_state", 64'(o_state), 64'd0);
    checkOutput("rel_ready", 64'(o_cfg_ready), 64'd1);

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
